// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, frame constants and the debug view
// exported by each direction of uart_transceiver.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Serial line levels for an 8N1 frame.
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;
  localparam logic LINE_IDLE  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

  // Per-direction observation point: FSM state, bit index and bit-timer flags.
  typedef struct packed {
    uart_state_e state;
    logic [2:0]  bit_idx;
    logic        half;
    logic        full;
  } uart_dbg_t;

endpackage

// File: rtl/uart_if.sv
// uart_if: host-side signals of uart_transceiver plus per-direction debug views.
//
// Handshake: i_Tx_DV is a one-cycle strobe with no ready; it is taken only when
// the TX FSM is idle (o_Tx_Active=0 and o_Tx_Done=0) and silently dropped
// otherwise. o_Tx_Done and o_Rx_DV are one-cycle pulses with no back-pressure;
// o_Rx_Byte is valid while o_Rx_DV=1 and holds until the next good frame.
`timescale 1ns/1ps
interface uart_if;
  import uart_pkg::*;

  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  uart_dbg_t  o_Tx_Dbg;
  uart_dbg_t  o_Rx_Dbg;

  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte,
    input  o_Tx_Dbg, o_Rx_Dbg
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte,
    output o_Tx_Dbg, o_Rx_Dbg
  );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-direction bit-period counter. Counts up from 0 after a
// clear and holds at the full-bit terminal value, so it never wraps in a bit.
`timescale 1ns/1ps
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Clear,
  output logic o_Half,
  output logic o_Full
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_Count;

  // Count clocks within a bit; clear restarts, saturate at the terminal count.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n)                r_Count <= '0;
    else if (i_Clear)            r_Count <= '0;
    else if (r_Count != FULL_CNT) r_Count <= r_Count + 1'b1;
  end

  assign o_Half = (r_Count == HALF_CNT);
  assign o_Full = (r_Count == FULL_CNT);
endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART, independent TX and RX FSMs on one clock.
// Build option: define UART_LOOPBACK_EN to feed RX from the TX line internally
// (i_Rx_Serial ignored); left undefined, RX listens to i_Rx_Serial.
`timescale 1ns/1ps
module uart_transceiver #(
  parameter int CLKS_PER_BIT = 87
) (
  input logic  i_Clock,
  input logic  i_Rst_n,
  uart_if.slave bus
);
  import uart_pkg::*;

  logic [1:0]  r_Rst_Sync;
  logic        w_Rst_n;
  uart_state_e r_Tx_State, w_Tx_Next;
  logic [7:0]  r_Tx_Data, w_Tx_Data_Next;
  logic [2:0]  r_Tx_Idx, w_Tx_Idx_Next;
  logic        w_Tx_Clear, w_Tx_Half, w_Tx_Full, w_Tx_Serial;
  uart_state_e r_Rx_State, w_Rx_Next;
  logic [7:0]  r_Rx_Shift, w_Rx_Shift_Next;
  logic [2:0]  r_Rx_Idx, w_Rx_Idx_Next;
  logic        w_Rx_Clear, w_Rx_Half, w_Rx_Full, w_Rx_In, w_Rx_Line, w_Rx_Valid;
  logic [1:0]  r_Rx_Sync;
  logic        r_Rx_DV;
  logic [7:0]  r_Rx_Byte;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) r_Rst_Sync <= 2'b00;
    else          r_Rst_Sync <= {r_Rst_Sync[0], 1'b1};
  end
  assign w_Rst_n = r_Rst_Sync[1];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .i_Clock(i_Clock), .i_Rst_n(w_Rst_n), .i_Clear(w_Tx_Clear),
    .o_Half(w_Tx_Half), .o_Full(w_Tx_Full)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .i_Clock(i_Clock), .i_Rst_n(w_Rst_n), .i_Clear(w_Rx_Clear),
    .o_Half(w_Rx_Half), .o_Full(w_Rx_Full)
  );

  // TX state register with latched byte and bit index.
  always_ff @(posedge i_Clock or negedge w_Rst_n) begin
    if (!w_Rst_n) begin
      r_Tx_State <= ST_IDLE;
      r_Tx_Data  <= '0;
      r_Tx_Idx   <= '0;
    end else begin
      r_Tx_State <= w_Tx_Next;
      r_Tx_Data  <= w_Tx_Data_Next;
      r_Tx_Idx   <= w_Tx_Idx_Next;
    end
  end

  // TX next state: strobes outside IDLE are dropped; timer restarts each bit.
  always_comb begin
    w_Tx_Next      = r_Tx_State;
    w_Tx_Data_Next = r_Tx_Data;
    w_Tx_Idx_Next  = r_Tx_Idx;
    w_Tx_Clear     = 1'b0;
    case (r_Tx_State)
      ST_IDLE: begin
        w_Tx_Clear    = 1'b1;
        w_Tx_Idx_Next = '0;
        if (bus.i_Tx_DV) begin
          w_Tx_Data_Next = bus.i_Tx_Byte;
          w_Tx_Next      = ST_START;
        end
      end
      ST_START: if (w_Tx_Full) begin
        w_Tx_Clear = 1'b1;
        w_Tx_Next  = ST_DATA;
      end
      ST_DATA: if (w_Tx_Full) begin
        w_Tx_Clear    = 1'b1;
        w_Tx_Idx_Next = r_Tx_Idx + 3'd1;
        if (r_Tx_Idx == 3'(DATA_BITS - 1)) w_Tx_Next = ST_STOP;
      end
      ST_STOP: if (w_Tx_Full) begin
        w_Tx_Clear = 1'b1;
        w_Tx_Next  = ST_CLEANUP;
      end
      default: begin
        w_Tx_Clear = 1'b1;
        w_Tx_Next  = ST_IDLE;
      end
    endcase
  end

  // TX line level decoded from the registered state, so reset forces idle-high at once.
  always_comb begin
    w_Tx_Serial = LINE_IDLE;
    case (r_Tx_State)
      ST_START: w_Tx_Serial = LINE_START;
      ST_DATA:  w_Tx_Serial = r_Tx_Data[r_Tx_Idx];
      ST_STOP:  w_Tx_Serial = LINE_STOP;
      default:  w_Tx_Serial = LINE_IDLE;
    endcase
  end

  assign bus.o_Tx_Serial = w_Tx_Serial;
  assign bus.o_Tx_Active = (r_Tx_State == ST_START) || (r_Tx_State == ST_DATA) ||
                           (r_Tx_State == ST_STOP);
  assign bus.o_Tx_Done   = (r_Tx_State == ST_CLEANUP);
  assign bus.o_Tx_Dbg    = '{state: r_Tx_State, bit_idx: r_Tx_Idx,
                             half: w_Tx_Half, full: w_Tx_Full};

`ifdef UART_LOOPBACK_EN
  assign w_Rx_In = w_Tx_Serial;
`else
  assign w_Rx_In = bus.i_Rx_Serial;
`endif

  // Two-flop synchroniser for the asynchronous RX line, idling high.
  always_ff @(posedge i_Clock or negedge w_Rst_n) begin
    if (!w_Rst_n) r_Rx_Sync <= {2{LINE_IDLE}};
    else          r_Rx_Sync <= {r_Rx_Sync[0], w_Rx_In};
  end
  assign w_Rx_Line = r_Rx_Sync[1];

  // RX state register, shift register and the held output byte / DV pulse.
  always_ff @(posedge i_Clock or negedge w_Rst_n) begin
    if (!w_Rst_n) begin
      r_Rx_State <= ST_IDLE;
      r_Rx_Shift <= '0;
      r_Rx_Idx   <= '0;
      r_Rx_DV    <= 1'b0;
      r_Rx_Byte  <= '0;
    end else begin
      r_Rx_State <= w_Rx_Next;
      r_Rx_Shift <= w_Rx_Shift_Next;
      r_Rx_Idx   <= w_Rx_Idx_Next;
      r_Rx_DV    <= w_Rx_Valid;
      if (w_Rx_Valid) r_Rx_Byte <= r_Rx_Shift;
    end
  end

  // RX next state: confirm start at mid-bit, then sample each following bit centre.
  always_comb begin
    w_Rx_Next       = r_Rx_State;
    w_Rx_Shift_Next = r_Rx_Shift;
    w_Rx_Idx_Next   = r_Rx_Idx;
    w_Rx_Clear      = 1'b0;
    w_Rx_Valid      = 1'b0;
    case (r_Rx_State)
      ST_IDLE: begin
        w_Rx_Clear    = 1'b1;
        w_Rx_Idx_Next = '0;
        if (w_Rx_Line == LINE_START) w_Rx_Next = ST_START;
      end
      ST_START: if (w_Rx_Half) begin
        w_Rx_Clear = 1'b1;
        w_Rx_Next  = (w_Rx_Line == LINE_START) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: if (w_Rx_Full) begin
        w_Rx_Clear      = 1'b1;
        w_Rx_Shift_Next = {w_Rx_Line, r_Rx_Shift[7:1]};
        w_Rx_Idx_Next   = r_Rx_Idx + 3'd1;
        if (r_Rx_Idx == 3'(DATA_BITS - 1)) w_Rx_Next = ST_STOP;
      end
      ST_STOP: if (w_Rx_Full) begin
        w_Rx_Clear = 1'b1;
        w_Rx_Valid = (w_Rx_Line == LINE_STOP);
        w_Rx_Next  = ST_CLEANUP;
      end
      default: begin
        w_Rx_Clear = 1'b1;
        w_Rx_Next  = ST_IDLE;
      end
    endcase
  end

  assign bus.o_Rx_DV   = r_Rx_DV;
  assign bus.o_Rx_Byte = r_Rx_Byte;
  assign bus.o_Rx_Dbg  = '{state: r_Rx_State, bit_idx: r_Rx_Idx,
                           half: w_Rx_Half, full: w_Rx_Full};
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed and randomized frames for uart_transceiver,
// TX looped to RX in the bench, RX also driven directly for error cases.
`timescale 1ns/1ps
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int CPB = 87;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #50 clk = ~clk;

  uart_if bus();

  logic loop_mode = 1'b1;
  logic bench_rx  = 1'b1;
  assign bus.i_Rx_Serial = loop_mode ? bus.o_Tx_Serial : bench_rx;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_byte_model = 8'h00;
  int dv_count   = 0;
  int done_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] sb_exp;
  always @(negedge clk) begin
    if (rst_n && bus.o_Rx_DV) begin
      dv_count++;
      check("rx_dv_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        check("rx_byte_at_dv", 32'(bus.o_Rx_Byte), 32'(sb_exp));
      end
    end
    if (rst_n && bus.o_Tx_Done) done_count++;
  end

  initial begin
    #(70000 * 100);
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_Tx_DV = 1'b0;
    repeat (5) @(posedge clk);
    #10 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    rx_byte_model = 8'h00;
  endtask

  // Send one byte and check the line at every bit centre plus Done timing.
  task automatic send_tx(input logic [7:0] b);
    logic [9:0] frame;
    int done_at, done_seen, m;
    frame = {LINE_STOP, b, LINE_START};
    done_at = 0;
    done_seen = 0;
    @(posedge clk); #1;
    bus.i_Tx_DV = 1'b1;
    bus.i_Tx_Byte = b;
    @(posedge clk); #1;
    bus.i_Tx_DV = 1'b0;
    bus.i_Tx_Byte = 8'($urandom);
    for (int n = 1; n <= 10 * CPB + 1; n++) begin
      @(negedge clk);
      m = n - 1;
      if (m < 10 * CPB && (m % CPB) == CPB / 2) begin
        check($sformatf("tx_line_bit%0d", m / CPB), 32'(bus.o_Tx_Serial), 32'(frame[m / CPB]));
        check("tx_active_in_frame", 32'(bus.o_Tx_Active), 32'd1);
      end
      if (bus.o_Tx_Done) begin
        done_seen++;
        if (done_at == 0) done_at = n;
      end
    end
    check("tx_done_latency", 32'(done_at), 32'(10 * CPB + 1));
    check("tx_done_pulses", 32'(done_seen), 32'd1);
    check("tx_active_at_done", 32'(bus.o_Tx_Active), 32'd0);
  endtask

  // Drive one frame straight onto i_Rx_Serial with a chosen stop level.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, LINE_START};
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      bench_rx = f[j];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    bench_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  int dv0, dn0;
  logic [7:0] rb;
  logic good;

  initial begin
    bus.i_Tx_DV = 1'b0;
    bus.i_Tx_Byte = 8'h00;
    #1;
    check("rst_tx_serial_held", 32'(bus.o_Tx_Serial), 32'd1);
    do_reset();
    @(negedge clk);
    check("rst_tx_serial", 32'(bus.o_Tx_Serial), 32'd1);
    check("rst_tx_active", 32'(bus.o_Tx_Active), 32'd0);
    check("rst_tx_done", 32'(bus.o_Tx_Done), 32'd0);
    check("rst_rx_dv", 32'(bus.o_Rx_DV), 32'd0);
    check("rst_rx_byte", 32'(bus.o_Rx_Byte), 32'd0);
    check("rst_rx_state", 32'(bus.o_Rx_Dbg.state), 32'(ST_IDLE));

    // Loopback of 0xAB.
    dv0 = dv_count;
    exp_q.push_back(8'hAB);
    send_tx(8'hAB);
    rx_byte_model = 8'hAB;
    check("t1_rx_byte", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));
    check("t1_dv_count", 32'(dv_count - dv0), 32'd1);

    // Short low glitch on RX.
    loop_mode = 1'b0;
    dv0 = dv_count;
    @(posedge clk); #1 bench_rx = 1'b0;
    repeat (30) @(posedge clk);
    #1 bench_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    check("t2_no_dv", 32'(dv_count - dv0), 32'd0);
    check("t2_rx_idle", 32'(bus.o_Rx_Dbg.state), 32'(ST_IDLE));
    check("t2_rx_byte_held", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));

    // Framing error, then a clean frame.
    rx_frame(8'h3F, 1'b0);
    check("t3_no_dv", 32'(dv_count - dv0), 32'd0);
    check("t3_rx_byte_held", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));
    check("t3_rx_idle", 32'(bus.o_Rx_Dbg.state), 32'(ST_IDLE));
    exp_q.push_back(8'h55);
    rx_frame(8'h55, 1'b1);
    rx_byte_model = 8'h55;
    check("t3_rx_byte_55", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));
    check("t3_dv_count", 32'(dv_count - dv0), 32'd1);
    loop_mode = 1'b1;

    // Strobe mid-frame is ignored.
    dv0 = dv_count;
    dn0 = done_count;
    exp_q.push_back(8'hAB);
    fork
      send_tx(8'hAB);
      begin
        repeat (300) @(posedge clk);
        #1 bus.i_Tx_DV = 1'b1;
        bus.i_Tx_Byte = 8'h00;
        @(posedge clk);
        #1 bus.i_Tx_DV = 1'b0;
      end
    join
    rx_byte_model = 8'hAB;
    repeat (2 * CPB) @(posedge clk);
    check("t4_tx_idle_after", 32'(bus.o_Tx_Active), 32'd0);
    check("t4_done_total", 32'(done_count - dn0), 32'd1);
    check("t4_dv_count", 32'(dv_count - dv0), 32'd1);
    check("t4_rx_byte", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));

    // Reset during TX data bit 3, then a fresh frame.
    dn0 = done_count;
    @(posedge clk); #1;
    bus.i_Tx_DV = 1'b1;
    bus.i_Tx_Byte = 8'hAB;
    @(posedge clk); #1;
    bus.i_Tx_DV = 1'b0;
    repeat (4 * CPB + 40) @(posedge clk);
    #5;
    check("t5_active_before_rst", 32'(bus.o_Tx_Active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx_serial", 32'(bus.o_Tx_Serial), 32'd1);
    check("t5_rst_tx_active", 32'(bus.o_Tx_Active), 32'd0);
    check("t5_rst_rx_byte", 32'(bus.o_Rx_Byte), 32'd0);
    rx_byte_model = 8'h00;
    repeat (4) @(posedge clk);
    #10 rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    check("t5_no_done", 32'(done_count - dn0), 32'd0);
    exp_q.push_back(8'h81);
    send_tx(8'h81);
    rx_byte_model = 8'h81;
    check("t5_rx_byte_81", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));

    // Back-to-back frames.
    dv0 = dv_count;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_tx(8'h00);
    send_tx(8'hFF);
    rx_byte_model = 8'hFF;
    check("t6_rx_byte", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));
    check("t6_dv_count", 32'(dv_count - dv0), 32'd2);

    // Randomized loopback bytes.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      exp_q.push_back(rb);
      send_tx(rb);
      rx_byte_model = rb;
      check("rand_loop_rx_byte", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));
    end

    // Randomized direct RX frames, some with a bad stop bit.
    loop_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      dv0 = dv_count;
      if (good) exp_q.push_back(rb);
      rx_frame(rb, good);
      if (good) rx_byte_model = rb;
      check("rand_rx_byte", 32'(bus.o_Rx_Byte), 32'(rx_byte_model));
      check("rand_rx_dv_count", 32'(dv_count - dv0), 32'(good));
    end
    loop_mode = 1'b1;

    repeat (10) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
